// File: rtl/audio_dl_pkg.sv
// Shared types and helpers for the multichannel audio delay line.
package audio_dl_pkg;

  typedef enum logic {ST_CLEAR, ST_RUN} dl_state_t;

  // A channel index is at least one bit wide, even for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dl_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first on collision.
module dl_dp_ram #(
  parameter int DATA_W = 16,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // Both assignments are non-blocking, so a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/multichannel_delay_line.sv
// Multi-channel circular sample history with random-access (channel, tap) reads,
// 2-cycle read pipeline and a zero-fill sweep after reset or clr.
module multichannel_delay_line
  import audio_dl_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 256,
  parameter int CHANNELS = 2,
  parameter int TAP_W    = $clog2(DEPTH),
  parameter int CH_W     = clog2_min1(CHANNELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rd_req,
  output logic              rd_ready,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [TAP_W-1:0]  rd_tap,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              ch_err
);

  localparam int AW      = CH_W + TAP_W;
  localparam int PHYS_CH = 1 << CH_W;
  localparam logic [AW-1:0]   SWEEP_LAST = AW'(CHANNELS * DEPTH - 1);
  localparam logic [CH_W:0]   CH_LIMIT   = (CH_W + 1)'(CHANNELS);

  dl_state_t         state, state_next;
  logic [AW-1:0]     sweep;
  logic [TAP_W-1:0]  wr_ptr [PHYS_CH];
  logic              wr_fire, rd_fire, wr_ch_ok, rd_ch_ok;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_wdata, ram_q;
  logic [TAP_W-1:0]  rd_slot;
  logic              rd_pend, rd_pend_ok;

  assign in_ready = (state == ST_RUN);
  assign rd_ready = (state == ST_RUN);
  assign busy     = (state == ST_CLEAR);

  assign wr_fire  = in_valid & in_ready;
  assign rd_fire  = rd_req & rd_ready;
  assign wr_ch_ok = ({1'b0, in_ch} < CH_LIMIT);
  assign rd_ch_ok = ({1'b0, rd_ch} < CH_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (!clr && sweep == SWEEP_LAST) state_next = ST_RUN;
      ST_RUN:   if (clr) state_next = ST_CLEAR;
      default:  state_next = ST_CLEAR;
    endcase
  end

  // The sweep idles at 0 in RUN so entering CLEAR always starts from address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        sweep <= '0;
    else if (clr || state == ST_RUN) sweep <= '0;
    else                            sweep <= sweep + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < PHYS_CH; c++) wr_ptr[c] <= '0;
    end else if (clr) begin
      for (int c = 0; c < PHYS_CH; c++) wr_ptr[c] <= '0;
    end else if (wr_fire && wr_ch_ok) begin
      wr_ptr[in_ch] <= wr_ptr[in_ch] + 1'b1;
    end
  end

  // Newest sample sits one slot behind the write pointer; all arithmetic wraps in TAP_W bits.
  assign rd_slot   = wr_ptr[rd_ch] - TAP_W'(1) - rd_tap;
  assign ram_raddr = {rd_ch, rd_slot};

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = sweep;
    ram_wdata = '0;
    if (state == ST_CLEAR) begin
      ram_we = 1'b1;
    end else if (wr_fire && wr_ch_ok) begin
      ram_we    = 1'b1;
      ram_waddr = {in_ch, wr_ptr[in_ch]};
      ram_wdata = in_data;
    end
  end

  dl_dp_ram #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend    <= 1'b0;
      rd_pend_ok <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      ch_err     <= 1'b0;
    end else begin
      rd_pend    <= rd_fire;
      rd_pend_ok <= rd_ch_ok;
      rd_valid   <= rd_pend;
      if (rd_pend) rd_data <= rd_pend_ok ? ram_q : '0;
      ch_err     <= (wr_fire && !wr_ch_ok) || (rd_fire && !rd_ch_ok);
    end
  end

endmodule

// File: tb/tb_multichannel_delay_line.sv
// Self-checking bench: directed vector table, hand-written clear/reset sequences and
// randomized traffic against a newest-first history model.
module tb_multichannel_delay_line;

  localparam int NCH = 2;
  localparam int DEP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [0:0]  in_ch = '0;
  logic [15:0] in_data = '0;
  logic        rd_req = 1'b0;
  logic        rd_ready;
  logic [0:0]  rd_ch = '0;
  logic [2:0]  rd_tap = '0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        busy;
  logic        ch_err;

  multichannel_delay_line #(
    .DATA_W   (16),
    .DEPTH    (DEP),
    .CHANNELS (NCH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ch    (in_ch),
    .in_data  (in_data),
    .rd_req   (rd_req),
    .rd_ready (rd_ready),
    .rd_ch    (rd_ch),
    .rd_tap   (rd_tap),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy),
    .ch_err   (ch_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: per-channel history, index 0 = newest sample.
  logic [15:0] hist [NCH][DEP];
  int          clear_left;
  logic        p1_v, out_v;
  logic [15:0] p1_d, out_d;
  int          p1_c, out_c;
  int          dir_exp = -1;

  typedef struct {
    logic        wr;
    logic        wch;
    logic [15:0] wd;
    logic        rd;
    logic        rch;
    logic [2:0]  tap;
    int          exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    clear_left = 16;
    for (int c = 0; c < NCH; c++)
      for (int t = 0; t < DEP; t++) hist[c][t] = '0;
    p1_v = 1'b0; p1_d = '0; p1_c = -1;
    out_v = 1'b0; out_d = '0; out_c = -1;
  endtask

  task automatic set_in(input logic wr, input logic wch, input logic [15:0] wd,
                        input logic rd, input logic rch, input logic [2:0] tap, input int exp);
    in_valid = wr; in_ch = wch; in_data = wd;
    rd_req = rd; rd_ch = rch; rd_tap = tap; dir_exp = exp;
  endtask

  // Advance one clock with the current inputs, update the model and compare every output.
  task automatic tick();
    logic        rdy, ra, wa;
    logic [15:0] val;
    rdy = (clear_left == 0);
    ra  = rd_req && rdy;
    wa  = in_valid && rdy;
    val = hist[rd_ch][rd_tap];
    out_v = p1_v;
    if (p1_v) begin out_d = p1_d; out_c = p1_c; end
    else out_c = -1;
    p1_v = ra; p1_d = val; p1_c = ra ? dir_exp : -1;
    if (wa) begin
      for (int t = DEP - 1; t > 0; t--) hist[in_ch][t] = hist[in_ch][t-1];
      hist[in_ch][0] = in_data;
    end
    if (clr) begin
      clear_left = 16;
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < DEP; t++) hist[c][t] = '0;
    end else if (clear_left > 0) begin
      clear_left--;
    end
    @(posedge clk); #1;
    check("rd_valid", rd_valid, out_v);
    check("rd_data", rd_data, out_d);
    if (out_v && out_c >= 0) check("vector_data", rd_data, out_c);
    check("busy", busy, clear_left != 0);
    check("in_ready", in_ready, clear_left == 0);
    check("rd_ready", rd_ready, clear_left == 0);
    check("ch_err", ch_err, 0);
    if (rd_valid) $display("read  data=0x%04h", rd_data);
  endtask

  task automatic wait_clear(input string name);
    int cnt;
    cnt = 0;
    set_in(0, 0, 0, 0, 0, 0, -1);
    while (busy && cnt < 40) begin
      cnt++;
      tick();
    end
    check(name, cnt, 16);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_rd_ready", rd_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_ch_err", ch_err, 0);
    rst = 1'b0;
    #1;
    wait_clear("reset_busy_len");

    // Directed table: empty history, wrap, same-cycle read/write, channel interleave.
    for (int i = 0; i < 8; i++) vecs.push_back('{0, 0, 16'h0, 1, 0, 3'(i), 0});
    for (int i = 1; i <= 10; i++) vecs.push_back('{1, 0, 16'(i), 0, 0, 3'd0, -1});
    for (int i = 0; i < 8; i++) vecs.push_back('{0, 0, 16'h0, 1, 0, 3'(i), 10 - i});
    vecs.push_back('{1, 0, 16'h00AA, 1, 0, 3'd7, 16'h0003});
    vecs.push_back('{0, 0, 16'h0000, 1, 0, 3'd0, 16'h00AA});
    vecs.push_back('{1, 0, 16'h00BB, 1, 0, 3'd0, 16'h00AA});
    vecs.push_back('{0, 0, 16'h0000, 1, 0, 3'd0, 16'h00BB});
    for (int i = 0; i < 3; i++) begin
      vecs.push_back('{1, 0, 16'h1111, 0, 0, 3'd0, -1});
      vecs.push_back('{1, 1, 16'h2222, 0, 0, 3'd0, -1});
    end
    vecs.push_back('{0, 0, 16'h0, 1, 0, 3'd0, 16'h1111});
    vecs.push_back('{0, 0, 16'h0, 1, 1, 3'd2, 16'h2222});
    vecs.push_back('{0, 0, 16'h0, 1, 1, 3'd3, 16'h0000});
    vecs.push_back('{0, 0, 16'h0, 1, 0, 3'd3, 16'h00BB});
    vecs.push_back('{0, 0, 16'h0, 0, 0, 3'd0, -1});
    vecs.push_back('{0, 0, 16'h0, 0, 0, 3'd0, -1});
    foreach (vecs[i]) begin
      set_in(vecs[i].wr, vecs[i].wch, vecs[i].wd, vecs[i].rd, vecs[i].rch, vecs[i].tap, vecs[i].exp);
      tick();
    end

    // Reads straddling clr keep pre-clear data; history is zero afterwards.
    set_in(0, 0, 0, 1, 0, 3'd0, 16'h1111);
    tick();
    clr = 1'b1;
    set_in(0, 0, 0, 1, 1, 3'd2, 16'h2222);
    tick();
    clr = 1'b0;
    wait_clear("clr_busy_len");
    set_in(0, 0, 0, 1, 0, 3'd0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, -1);
    repeat (2) tick();

    // Randomized traffic, including occasional clr pulses.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 1), 1'($urandom_range(0, 1)), 16'($urandom),
             $urandom_range(0, 1), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), -1);
      clr = ($urandom_range(0, 79) == 0);
      tick();
    end
    clr = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, -1);
    repeat (20) tick();

    // Asynchronous reset with reads in flight.
    set_in(1, 1, 16'h5A5A, 0, 0, 0, -1);
    tick();
    set_in(0, 0, 0, 1, 1, 3'd0, 16'h5A5A);
    tick();
    set_in(0, 0, 0, 1, 1, 3'd1, -1);
    tick();
    set_in(0, 0, 0, 1, 1, 3'd0, -1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_rd_valid", rd_valid, 0);
    check("arst_rd_data", rd_data, 0);
    check("arst_busy", busy, 1);
    check("arst_in_ready", in_ready, 0);
    check("arst_rd_ready", rd_ready, 0);
    check("arst_ch_err", ch_err, 0);
    set_in(0, 0, 0, 0, 0, 0, -1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("arst_hold_rd_valid", rd_valid, 0);
    end
    rst = 1'b0;
    model_reset();
    #1;
    wait_clear("rerst_busy_len");
    set_in(0, 0, 0, 1, 1, 3'd0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, -1);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
